// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer.
// Holds the FSM state encoding, the default reset and trap vectors, and the
// next-PC select codes that the sequencer passes to pc_next_mux.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_TRAP = 3'd3,
    SEL_EPC  = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0010;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the pipeline and the PC sequencer.
// master: pipeline side, drives the request inputs and observes the PC.
// slave : sequencer side, consumes requests and drives pc, pc_valid,
//         flush, epc, ie and state.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);

  logic                    stall;
  logic                    br_taken;
  logic signed [WIDTH-1:0] br_offset;
  logic                    jmp;
  logic        [WIDTH-1:0] jmp_target;
  logic                    irq;
  logic                    eret;
  logic                    halt_req;
  logic                    resume;
  logic        [WIDTH-1:0] pc;
  logic                    pc_valid;
  logic                    flush;
  logic        [WIDTH-1:0] epc;
  logic                    ie;
  logic        [1:0]       state;

  modport master (
    output stall, br_taken, br_offset, jmp, jmp_target, irq, eret,
           halt_req, resume,
    input  pc, pc_valid, flush, epc, ie, state
  );

  modport slave (
    input  stall, br_taken, br_offset, jmp, jmp_target, irq, eret,
           halt_req, resume,
    output pc, pc_valid, flush, epc, ie, state
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC datapath.
// Inputs : pc, epc, jmp_target, signed br_offset, select code sel.
// Outputs: pc_next (selected next fetch address), pc_inc (pc + 1, also used
//          as the saved return address on trap entry).
// All arithmetic wraps modulo 2^WIDTH.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEF_TRAP_VEC)
) (
  input  logic        [WIDTH-1:0] pc,
  input  logic        [WIDTH-1:0] epc,
  input  logic        [WIDTH-1:0] jmp_target,
  input  logic signed [WIDTH-1:0] br_offset,
  input  pc_sel_e                 sel,
  output logic        [WIDTH-1:0] pc_next,
  output logic        [WIDTH-1:0] pc_inc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [WIDTH-1:0] pc_s;
  logic signed [WIDTH-1:0] br_sum_s;

  // Two's-complement add of the signed offset; overflow wraps silently.
  assign pc_s     = $signed(pc);
  assign br_sum_s = pc_s + br_offset;
  assign pc_inc   = pc + ONE;

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_SEQ:  pc_next = pc_inc;
      SEL_BR:   pc_next = $unsigned(br_sum_s);
      SEL_JMP:  pc_next = jmp_target;
      SEL_TRAP: pc_next = TRAP_VEC;
      SEL_EPC:  pc_next = epc;
      SEL_HOLD: pc_next = pc;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage.
// Arbitrates sequential fetch, relative branch, absolute jump, interrupt
// entry/return, stall and halt, and presents the fetch address with its
// valid and flush strobes.
// Ports: clk, rst (synchronous, active-high), bus (pc_sequencer_if.slave)
//        carrying the request inputs and pc/pc_valid/flush/epc/ie/state.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC)
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             ie_q, ie_d;
  logic             flush_q, flush_d;
  logic             pc_valid_q, pc_valid_d;
  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_inc;

  pc_next_mux #(
    .WIDTH    (WIDTH),
    .TRAP_VEC (TRAP_VEC)
  ) u_next (
    .pc         (pc_q),
    .epc        (epc_q),
    .jmp_target (bus.jmp_target),
    .br_offset  (bus.br_offset),
    .sel        (sel),
    .pc_next    (pc_d),
    .pc_inc     (pc_inc)
  );

  always_comb begin
    state_d    = state_q;
    sel        = SEL_HOLD;
    epc_d      = epc_q;
    ie_d       = ie_q;
    flush_d    = 1'b0;
    pc_valid_d = pc_valid_q;
    case (state_q)
      ST_RUN: begin
        pc_valid_d = 1'b1;
        if (bus.halt_req) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything; a pending irq waits until the stall clears.
          sel = SEL_HOLD;
        end else if (bus.irq && ie_q) begin
          // Trap entry discards any simultaneous eret/jmp/branch.
          sel        = SEL_TRAP;
          epc_d      = pc_inc;
          ie_d       = 1'b0;
          state_d    = ST_TRAP;
          pc_valid_d = 1'b0;
          flush_d    = 1'b1;
        end else if (bus.eret) begin
          sel     = SEL_EPC;
          ie_d    = 1'b1;
          flush_d = 1'b1;
        end else if (bus.jmp) begin
          sel     = SEL_JMP;
          flush_d = 1'b1;
        end else if (bus.br_taken) begin
          sel     = SEL_BR;
          flush_d = 1'b1;
        end else begin
          sel = SEL_SEQ;
        end
      end
      ST_TRAP: begin
        // One bubble cycle at TRAP_VEC, then fetch TRAP_VEC for real.
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_HALT: begin
        pc_valid_d = 1'b0;
        if (!bus.halt_req && bus.resume) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
    endcase
  end

  // Register stage: all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      ie_q       <= 1'b1;
      flush_q    <= 1'b0;
      pc_valid_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      ie_q       <= ie_d;
      flush_q    <= flush_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.epc      = epc_q;
  assign bus.ie       = ie_q;
  assign bus.state    = state_q;

endmodule
